// File: rtl/next_pc_stack_pkg.sv
// next_pc_stack_pkg
//   Shared defaults and the next-PC select encoding for the next-PC unit and
//   its return-address stack.
package next_pc_stack_pkg;

  localparam int ADDR_W_DEF    = 8;
  localparam int RAS_DEPTH_DEF = 4;

  // Next-PC source, listed in decreasing priority.
  typedef enum logic [2:0] {
    SEL_HOLD   = 3'd0,
    SEL_RET    = 3'd1,
    SEL_CALL   = 3'd2,
    SEL_JUMP   = 3'd3,
    SEL_BRANCH = 3'd4,
    SEL_SEQ    = 3'd5
  } next_sel_e;

endpackage

// File: rtl/next_pc_stack_ras_stack.sv
// ras_stack
//   Circular return-address stack with a depth counter and sticky
//   overflow/underflow flags.
//   Ports:
//     clock, reset_n     : clock, async active-low reset
//     push, pop          : push push_data / pop top entry (push wins if both)
//     push_data          : return address to store
//     top_data           : current top-of-stack entry
//     empty, full        : depth == 0 / depth == RAS_DEPTH
//     overflow, underflow: sticky, cleared only by reset
module ras_stack
  import next_pc_stack_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top_data,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  localparam int PTR_W   = $clog2(RAS_DEPTH);
  localparam int DEPTH_W = $clog2(RAS_DEPTH + 1);
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(RAS_DEPTH);

  // ptr_r indexes the next free slot; when full it points at the oldest
  // entry, so a push while full naturally overwrites the oldest one.
  logic [ADDR_W-1:0]  entries_r [RAS_DEPTH];
  logic [PTR_W-1:0]   ptr_r;
  logic [DEPTH_W-1:0] depth_r;
  logic               overflow_r;
  logic               underflow_r;

  logic [PTR_W-1:0]   top_idx_s;
  logic               empty_s;
  logic               full_s;

  assign top_idx_s = ptr_r - PTR_W'(1);
  assign empty_s   = (depth_r == {DEPTH_W{1'b0}});
  assign full_s    = (depth_r == DEPTH_MAX);

  assign top_data  = entries_r[top_idx_s];
  assign empty     = empty_s;
  assign full      = full_s;
  assign overflow  = overflow_r;
  assign underflow = underflow_r;

  // Stack storage, pointer, depth and sticky flag update.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        entries_r[i] <= {ADDR_W{1'b0}};
      end
      ptr_r       <= {PTR_W{1'b0}};
      depth_r     <= {DEPTH_W{1'b0}};
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else if (push) begin
      entries_r[ptr_r] <= push_data;
      ptr_r            <= ptr_r + PTR_W'(1);
      if (full_s) begin
        overflow_r <= 1'b1;
      end else begin
        depth_r <= depth_r + DEPTH_W'(1);
      end
    end else if (pop) begin
      if (empty_s) begin
        underflow_r <= 1'b1;
      end else begin
        ptr_r   <= top_idx_s;
        depth_r <= depth_r - DEPTH_W'(1);
      end
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/next_pc_stack.sv
// next_pc_stack
//   Next-PC selection with a return-address stack for call/ret.
//   prox_pc is combinational so the PC register captures it on the same edge
//   that updates the stack.
//   Ports:
//     clock, reset_n             : clock, async active-low reset
//     pc_atual                   : current PC
//     stall                      : hold PC, freeze stack
//     branch_taken/branch_offset : PC-relative branch
//     jump/jump_target           : absolute jump (target also used by call)
//     call, ret                  : push return address / pop and return
//     prox_pc                    : next PC (0 while in reset)
//     ras_empty, ras_full        : stack depth status
//     ras_overflow/ras_underflow : sticky error flags
module next_pc_stack
  import next_pc_stack_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] pc_atual,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_offset,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              call,
  input  logic              ret,
  output logic [ADDR_W-1:0] prox_pc,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_overflow,
  output logic              ras_underflow
);

  next_sel_e         sel_s;
  logic [ADDR_W-1:0] pc_inc_s;
  logic [ADDR_W-1:0] branch_tgt_s;
  logic [ADDR_W-1:0] ras_top_s;
  logic [ADDR_W-1:0] prox_pc_s;
  logic              push_s;
  logic              pop_s;
  logic              ras_empty_s;

  // Adders wrap modulo 2^ADDR_W by construction.
  assign pc_inc_s     = pc_atual + ADDR_W'(1);
  assign branch_tgt_s = pc_atual + branch_offset;

  // ret beats call, so a simultaneous call never pushes.
  assign push_s = call & ~ret & ~stall;
  assign pop_s  = ret & ~stall;

  ras_stack #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push_s),
    .pop       (pop_s),
    .push_data (pc_inc_s),
    .top_data  (ras_top_s),
    .empty     (ras_empty_s),
    .full      (ras_full),
    .overflow  (ras_overflow),
    .underflow (ras_underflow)
  );

  assign ras_empty = ras_empty_s;

  // Priority select; a ret on an empty stack falls back to sequential.
  always_comb begin
    sel_s = SEL_SEQ;
    if (stall) begin
      sel_s = SEL_HOLD;
    end else if (ret) begin
      if (ras_empty_s) begin
        sel_s = SEL_SEQ;
      end else begin
        sel_s = SEL_RET;
      end
    end else if (call) begin
      sel_s = SEL_CALL;
    end else if (jump) begin
      sel_s = SEL_JUMP;
    end else if (branch_taken) begin
      sel_s = SEL_BRANCH;
    end else begin
      sel_s = SEL_SEQ;
    end
  end

  // Next-PC mux; forced to zero while reset is asserted.
  always_comb begin
    prox_pc_s = pc_inc_s;
    if (!reset_n) begin
      prox_pc_s = {ADDR_W{1'b0}};
    end else begin
      case (sel_s)
        SEL_HOLD:   prox_pc_s = pc_atual;
        SEL_RET:    prox_pc_s = ras_top_s;
        SEL_CALL:   prox_pc_s = jump_target;
        SEL_JUMP:   prox_pc_s = jump_target;
        SEL_BRANCH: prox_pc_s = branch_tgt_s;
        SEL_SEQ:    prox_pc_s = pc_inc_s;
        default:    prox_pc_s = pc_inc_s;
      endcase
    end
  end

  assign prox_pc = prox_pc_s;

endmodule

// File: tb/tb_next_pc_stack.sv
// Directed table-driven bench for next_pc_stack (default parameters).
module tb_next_pc_stack;

  logic       clock;
  logic       reset_n;
  logic [7:0] pc_atual;
  logic       stall;
  logic       branch_taken;
  logic [7:0] branch_offset;
  logic       jump;
  logic [7:0] jump_target;
  logic       call;
  logic       ret;
  logic [7:0] prox_pc;
  logic       ras_empty;
  logic       ras_full;
  logic       ras_overflow;
  logic       ras_underflow;

  int n_vec;
  int n_bad;

  next_pc_stack dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .pc_atual      (pc_atual),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_target   (jump_target),
    .call          (call),
    .ret           (ret),
    .prox_pc       (prox_pc),
    .ras_empty     (ras_empty),
    .ras_full      (ras_full),
    .ras_overflow  (ras_overflow),
    .ras_underflow (ras_underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] pc;
    logic       stl;
    logic       br;
    logic [7:0] off;
    logic       jmp;
    logic [7:0] tgt;
    logic       cal;
    logic       rt;
    logic [7:0] exp_pc;
    logic       exp_e;
    logic       exp_f;
    logic       exp_o;
    logic       exp_u;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] pc, input logic stl, input logic br,
                              input logic [7:0] off, input logic jmp, input logic [7:0] tgt,
                              input logic cal, input logic rt, input logic [7:0] exp_pc,
                              input logic e, input logic f, input logic o, input logic u);
    vec_t v;
    v = '{pc, stl, br, off, jmp, tgt, cal, rt, exp_pc, e, f, o, u};
    return v;
  endfunction

  task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got pc=%h e/f/o/u=%b required pc=%h e/f/o/u=%b",
               name, got[11:4], got[3:0], exp[11:4], exp[3:0]);
    end
  endtask

  // Drive a vector after the falling edge, compare outputs before the rising edge.
  task automatic apply(input string name, input vec_t v);
    @(negedge clock);
    pc_atual      = v.pc;
    stall         = v.stl;
    branch_taken  = v.br;
    branch_offset = v.off;
    jump          = v.jmp;
    jump_target   = v.tgt;
    call          = v.cal;
    ret           = v.rt;
    #1;
    check(name, {prox_pc, ras_empty, ras_full, ras_overflow, ras_underflow},
          {v.exp_pc, v.exp_e, v.exp_f, v.exp_o, v.exp_u});
  endtask

  vec_t tbl [28];

  initial begin
    n_vec = 0;
    n_bad = 0;

    // Table: pc stl br off jmp tgt cal ret | exp_pc e f o u (flags before the edge)
    tbl[0]  = mk(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[1]  = mk(8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[2]  = mk(8'h10, 1'b0, 1'b1, 8'hFC, 1'b0, 8'h00, 1'b0, 1'b0, 8'h0C, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[3]  = mk(8'h20, 1'b0, 1'b0, 8'h00, 1'b1, 8'h40, 1'b0, 1'b0, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[4]  = mk(8'h20, 1'b0, 1'b1, 8'h04, 1'b1, 8'h50, 1'b0, 1'b0, 8'h50, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[5]  = mk(8'h05, 1'b0, 1'b0, 8'h00, 1'b0, 8'h30, 1'b1, 1'b0, 8'h30, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[6]  = mk(8'h37, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h06, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[7]  = mk(8'h06, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
    // Five calls from 01..05, the fifth one while full.
    tbl[8]  = mk(8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 8'h80, 1'b1, 1'b0, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[9]  = mk(8'h02, 1'b0, 1'b0, 8'h00, 1'b0, 8'h80, 1'b1, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[10] = mk(8'h03, 1'b0, 1'b0, 8'h00, 1'b0, 8'h80, 1'b1, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[11] = mk(8'h04, 1'b0, 1'b0, 8'h00, 1'b0, 8'h80, 1'b1, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[12] = mk(8'h05, 1'b0, 1'b0, 8'h00, 1'b0, 8'h80, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0);
    // Four pops give 06,05,04,03 (02 was overwritten), fifth underflows.
    tbl[13] = mk(8'h90, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h06, 1'b0, 1'b1, 1'b1, 1'b0);
    tbl[14] = mk(8'h90, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[15] = mk(8'h90, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[16] = mk(8'h90, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[17] = mk(8'h90, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h91, 1'b1, 1'b0, 1'b1, 1'b0);
    tbl[18] = mk(8'h91, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h92, 1'b1, 1'b0, 1'b1, 1'b1);
    // Stall during call: PC held, nothing pushed.
    tbl[19] = mk(8'hA0, 1'b1, 1'b0, 8'h00, 1'b0, 8'hB0, 1'b1, 1'b0, 8'hA0, 1'b1, 1'b0, 1'b1, 1'b1);
    tbl[20] = mk(8'hA0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA1, 1'b1, 1'b0, 1'b1, 1'b1);
    // Call+ret with depth 1: pop only.
    tbl[21] = mk(8'h10, 1'b0, 1'b0, 8'h00, 1'b0, 8'h20, 1'b1, 1'b0, 8'h20, 1'b1, 1'b0, 1'b1, 1'b1);
    tbl[22] = mk(8'h30, 1'b0, 1'b0, 8'h00, 1'b0, 8'h40, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1);
    tbl[23] = mk(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b1, 1'b1);
    // Stall during ret keeps the entry.
    tbl[24] = mk(8'h60, 1'b0, 1'b0, 8'h00, 1'b0, 8'h70, 1'b1, 1'b0, 8'h70, 1'b1, 1'b0, 1'b1, 1'b1);
    tbl[25] = mk(8'h70, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h70, 1'b0, 1'b0, 1'b1, 1'b1);
    tbl[26] = mk(8'h70, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h61, 1'b0, 1'b0, 1'b1, 1'b1);
    tbl[27] = mk(8'h61, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h62, 1'b1, 1'b0, 1'b1, 1'b1);

    // Reset with busy inputs: outputs forced to their reset values.
    reset_n       = 1'b0;
    pc_atual      = 8'h33;
    stall         = 1'b0;
    branch_taken  = 1'b1;
    branch_offset = 8'h07;
    jump          = 1'b1;
    jump_target   = 8'h77;
    call          = 1'b1;
    ret           = 1'b0;
    #3;
    check("reset_state", {prox_pc, ras_empty, ras_full, ras_overflow, ras_underflow},
          {8'h00, 1'b1, 1'b0, 1'b0, 1'b0});
    @(posedge clock);
    #1;
    check("reset_held", {prox_pc, ras_empty, ras_full, ras_overflow, ras_underflow},
          {8'h00, 1'b1, 1'b0, 1'b0, 1'b0});
    @(negedge clock);
    call         = 1'b0;
    jump         = 1'b0;
    branch_taken = 1'b0;
    reset_n      = 1'b1;

    for (int i = 0; i < 28; i++) begin
      apply($sformatf("vec%0d", i), tbl[i]);
    end

    // Async reset between edges with depth 3.
    apply("pre_rst_call1", mk(8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 8'h80, 1'b1, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1, 1'b1));
    apply("pre_rst_call2", mk(8'h02, 1'b0, 1'b0, 8'h00, 1'b0, 8'h80, 1'b1, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1));
    apply("pre_rst_call3", mk(8'h03, 1'b0, 1'b0, 8'h00, 1'b0, 8'h80, 1'b1, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1));
    @(negedge clock);
    call        = 1'b0;
    jump        = 1'b1;
    jump_target = 8'h55;
    pc_atual    = 8'h04;
    #1;
    check("depth3_before_rst", {prox_pc, ras_empty, ras_full, ras_overflow, ras_underflow},
          {8'h55, 1'b0, 1'b0, 1'b1, 1'b1});
    #1 reset_n = 1'b0;
    #1;
    check("async_rst", {prox_pc, ras_empty, ras_full, ras_overflow, ras_underflow},
          {8'h00, 1'b1, 1'b0, 1'b0, 1'b0});
    #1 reset_n = 1'b1;
    apply("post_rst_ret", mk(8'h42, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h43, 1'b1, 1'b0, 1'b0, 1'b0));
    apply("post_rst_seq", mk(8'h43, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h44, 1'b1, 1'b0, 1'b0, 1'b1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
